shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 103 ++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: bit-serial ARM-style barrel shifter, one shift step per clock.
module shift_sequencer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] operand_i,
    input  logic [11:0] amount_i,
    input  logic [7:0]  rs_i,
    input  logic        iso_i,
    input  logic        reg_shift_i,
    input  logic        cin_i,
    output logic [31:0] out_o,
    output logic        cout_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [2:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX} op_t;

    state_t      state_q;
    op_t         op_q, op_d;
    logic [31:0] w_q, w_d, w_step;
    logic        c_q, c_d, c_step;
    logic [5:0]  n_q, n_d, n_imm, n_reg;
    logic        busy_q, done_q;
    logic [4:0]  imm_n;
    logic [1:0]  typ;

    assign imm_n = amount_i[11:7];
    assign typ   = amount_i[6:5];

    // Step count is saturated here so the 6-bit counter never has to wrap.
    always_comb begin
        n_imm = (typ == 2'd0) ? {1'b0, imm_n} :
                (typ == 2'd3) ? ((imm_n == 5'd0) ? 6'd1 : {1'b0, imm_n}) :
                ((imm_n == 5'd0) ? 6'd32 : {1'b0, imm_n});
        n_reg = (rs_i == 8'd0) ? 6'd0 :
                (typ == 2'd3) ? ((rs_i[4:0] == 5'd0) ? 6'd32 : {1'b0, rs_i[4:0]}) :
                (typ == 2'd2) ? ((rs_i > 8'd32) ? 6'd32 : rs_i[5:0]) :
                ((rs_i > 8'd33) ? 6'd33 : rs_i[5:0]);
        n_d  = iso_i ? {1'b0, amount_i[11:8], 1'b0} : (reg_shift_i ? n_reg : n_imm);
        w_d  = iso_i ? {24'b0, amount_i[7:0]} : operand_i;
        c_d  = cin_i;
        op_d = iso_i ? OP_ROR :
               (!reg_shift_i && typ == 2'd3 && imm_n == 5'd0) ? OP_RRX : op_t'({1'b0, typ});
    end

    always_comb begin
        w_step = (op_q == OP_LSL) ? {w_q[30:0], 1'b0} :
                 (op_q == OP_LSR) ? {1'b0, w_q[31:1]} :
                 (op_q == OP_ASR) ? {w_q[31], w_q[31:1]} :
                 (op_q == OP_ROR) ? {w_q[0], w_q[31:1]} :
                 {c_q, w_q[31:1]};
        c_step = (op_q == OP_LSL) ? w_q[31] : w_q[0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= OP_LSL;
            w_q     <= 32'd0;
            c_q     <= 1'b0;
            n_q     <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        w_q     <= w_d;
                        c_q     <= c_d;
                        n_q     <= n_d;
                        op_q    <= op_d;
                        state_q <= (n_d != 6'd0) ? SHIFT : DONE;
                        busy_q  <= (n_d != 6'd0);
                        done_q  <= (n_d == 6'd0);
                    end
                end
                SHIFT: begin
                    w_q     <= w_step;
                    c_q     <= c_step;
                    n_q     <= n_q - 6'd1;
                    state_q <= (n_q == 6'd1) ? DONE : SHIFT;
                    busy_q  <= (n_q != 6'd1);
                    done_q  <= (n_q == 6'd1);
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_o  = w_q;
    assign cout_o = c_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule
